mem_load_sequencer: RTL and testbench

//  Boot/run controller for the single-cycle MIPS datapath. Accepts a 32-bit word stream from the host

---
 rtl/mem_load_sequencer.sv | 159 +++++++++++++++
 tb/tb_mem_load_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_sequencer.sv
// Boot/run controller for the single-cycle MIPS datapath: streams host words into instruction and
// data memory over valid/ready, then releases the datapath and counts run cycles until halt.
module mem_load_sequencer #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  inst_count,
   input  logic [CNT_W-1:0]  data_count,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              cpu_run,
   input  logic              halt_req,
   output logic              done,
   output logic [31:0]       run_cycles
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoadI = 3'd1;
   localparam logic [2:0] StLoadD = 3'd2;
   localparam logic [2:0] StRun   = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(1) << ADDR_W;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  icnt_q, icnt_d;
   logic [CNT_W-1:0]  dcnt_q, dcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              imem_we_q, imem_we_d;
   logic              dmem_we_q, dmem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       run_cycles_q, run_cycles_d;

   logic              xfer;
   logic              last_i;
   logic              last_d;
   logic [CNT_W-1:0]  addr_ext;
   logic [CNT_W-1:0]  icnt_clamped;
   logic [CNT_W-1:0]  dcnt_clamped;

   assign in_ready = (state_q == StLoadI) || (state_q == StLoadD);
   assign cpu_run  = (state_q == StRun);
   assign cpu_rst  = !cpu_run;
   assign done     = (state_q == StDone);

   assign imem_we    = imem_we_q;
   assign dmem_we    = dmem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign run_cycles = run_cycles_q;

   assign xfer         = in_valid && in_ready;
   assign addr_ext     = CNT_W'(addr_q);
   assign last_i       = (addr_ext == icnt_q - CNT_W'(1));
   assign last_d       = (addr_ext == dcnt_q - CNT_W'(1));
   assign icnt_clamped = (inst_count > MaxCnt) ? MaxCnt : inst_count;
   assign dcnt_clamped = (data_count > MaxCnt) ? MaxCnt : data_count;

   always_comb begin
      state_d      = state_q;
      icnt_d       = icnt_q;
      dcnt_d       = dcnt_q;
      addr_d       = addr_q;
      imem_we_d    = 1'b0;
      dmem_we_d    = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      run_cycles_d = run_cycles_q;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               icnt_d       = icnt_clamped;
               dcnt_d       = dcnt_clamped;
               run_cycles_d = 32'd0;
               addr_d       = '0;
               if (icnt_clamped != '0) begin
                  state_d = StLoadI;
               end else if (dcnt_clamped != '0) begin
                  state_d = StLoadD;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StLoadI: begin
            if (xfer) begin
               mem_wdata_d = in_data;
               mem_addr_d  = addr_q;
               imem_we_d   = 1'b1;
               addr_d      = addr_q + 1'b1;
               // Address restarts at 0 for the data region, never wraps mid-region.
               if (last_i) begin
                  addr_d  = '0;
                  state_d = (dcnt_q != '0) ? StLoadD : StRun;
               end
            end
         end
         StLoadD: begin
            if (xfer) begin
               mem_wdata_d = in_data;
               mem_addr_d  = addr_q;
               dmem_we_d   = 1'b1;
               addr_d      = addr_q + 1'b1;
               if (last_d) begin
                  addr_d  = '0;
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (run_cycles_q != 32'hFFFF_FFFF) begin
               run_cycles_d = run_cycles_q + 32'd1;
            end
            if (halt_req) begin
               state_d = StDone;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         icnt_q       <= '0;
         dcnt_q       <= '0;
         addr_q       <= '0;
         imem_we_q    <= 1'b0;
         dmem_we_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         run_cycles_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         icnt_q       <= icnt_d;
         dcnt_q       <= dcnt_d;
         addr_q       <= addr_d;
         imem_we_q    <= imem_we_d;
         dmem_we_q    <= dmem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         run_cycles_q <= run_cycles_d;
      end
   end

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Scoreboard bench for mem_load_sequencer: expected memory writes are queued from a reference
// model of the load order; a monitor pops and compares every write pulse the DUT presents.
module tb_mem_load_sequencer;

   localparam int ADDR_W = 10;
   localparam int CNT_W  = 11;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [CNT_W-1:0]  inst_count;
   logic [CNT_W-1:0]  data_count;
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_ready;
   logic              imem_we;
   logic              dmem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst;
   logic              cpu_run;
   logic              halt_req;
   logic              done;
   logic [31:0]       run_cycles;

   mem_load_sequencer #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .inst_count(inst_count),
      .data_count(data_count),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .imem_we   (imem_we),
      .dmem_we   (dmem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .cpu_run   (cpu_run),
      .halt_req  (halt_req),
      .done      (done),
      .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   // {imem, dmem, addr, data}
   typedef struct packed {
      logic              is_i;
      logic              is_d;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] words[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          mon_hs_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every write pulse must match the queue head and follow a handshake by one cycle.
   always @(negedge clk) begin
      wr_t got;
      wr_t want;
      got = '{is_i: imem_we, is_d: dmem_we, addr: mem_addr, data: mem_wdata};
      if (imem_we || dmem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 64'(got), 64'd0);
         end else begin
            want = exp_q.pop_front();
            check("write", 64'(got), 64'(want));
         end
      end
      if (imem_we || dmem_we || mon_hs_prev) begin
         check("write_lag", 64'(imem_we || dmem_we), 64'(mon_hs_prev));
      end
      mon_hs_prev = in_valid && in_ready && !rst;
   end

   function automatic int clampc(input int c);
      return (c > DEPTH) ? DEPTH : c;
   endfunction

   task automatic do_start(input int ic, input int dc);
      inst_count = CNT_W'(ic);
      data_count = CNT_W'(dc);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 0: valid held, 1: alternating, 2: random gaps (with random halt_req noise)
   task automatic send_stream(input int n, input int mode, input bit pulse_start);
      int idx = 0;
      int cyc = 0;
      bit acc;
      while (idx < n && cyc < n * 4 + 50) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 2) == 0;
            default: in_valid = $urandom_range(0, 2) != 0;
         endcase
         if (mode == 2) halt_req = $urandom_range(0, 1) != 0;
         in_data = words[idx];
         if (pulse_start) begin
            start      = $urandom_range(0, 1) != 0;
            inst_count = CNT_W'(5);
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      halt_req = 1'b0;
      if (idx < n) check("stream_timeout", 64'(idx), 64'(n));
   endtask

   // Reference: instruction words land at 0..ic-1, then data words at 0..dc-1, in stream order.
   task automatic load_test(input int ic, input int dc, input int mode, input bit pulse_start);
      int ci = clampc(ic);
      int cd = clampc(dc);
      words.delete();
      for (int i = 0; i < ci + cd; i++) words.push_back($urandom);
      for (int i = 0; i < ci; i++) exp_q.push_back('{1'b1, 1'b0, ADDR_W'(i), words[i]});
      for (int i = 0; i < cd; i++) exp_q.push_back('{1'b0, 1'b1, ADDR_W'(i), words[ci + i]});
      do_start(ic, dc);
      send_stream(ci + cd, mode, pulse_start);
      @(negedge clk);
      check("run_after_load", 64'(cpu_run), 64'd1);
      check("ready_after_load", 64'(in_ready), 64'd0);
      check("cpu_rst_in_run", 64'(cpu_rst), 64'd0);
   endtask

   task automatic run_and_halt(input int n);
      for (int i = 1; i <= n; i++) begin
         halt_req = (i == n);
         @(posedge clk); #1;
      end
      halt_req = 1'b0;
      @(negedge clk);
      check("done", 64'(done), 64'd1);
      check("run_cycles", 64'(run_cycles), 64'(n));
      check("cpu_run_done", 64'(cpu_run), 64'd0);
      check("cpu_rst_done", 64'(cpu_rst), 64'd1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      inst_count = '0;
      data_count = '0;
      in_valid   = 1'b0;
      in_data    = 32'd0;
      halt_req   = 1'b0;

      // T1 reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("rst_imem_we", 64'(imem_we), 64'd0);
      check("rst_dmem_we", 64'(dmem_we), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_run_cycles", 64'(run_cycles), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_cpu_run", 64'(cpu_run), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // T2 held valid across the instruction/data boundary
      load_test(3, 2, 0, 1'b0);
      run_and_halt(4);

      // T3 alternating valid, instruction only (start from DONE)
      load_test(4, 0, 1, 1'b0);
      run_and_halt(2);

      // T4 zero counts: straight to RUN
      do_start(0, 0);
      @(negedge clk);
      check("zero_cnt_run", 64'(cpu_run), 64'd1);
      run_and_halt(6);

      // T5 reset mid-load, with a handshake on the reset edge that must be dropped
      words.delete();
      for (int i = 0; i < 8; i++) words.push_back($urandom);
      for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, 1'b0, ADDR_W'(i), words[i]});
      do_start(8, 0);
      send_stream(3, 0, 1'b0);
      in_valid = 1'b1;
      in_data  = words[3];
      rst      = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
      check("mid_rst_ready", 64'(in_ready), 64'd0);
      check("mid_rst_we", 64'(imem_we || dmem_we), 64'd0);
      load_test(2, 1, 0, 1'b0);
      run_and_halt(1);

      // Data only, random gaps
      load_test(0, 3, 2, 1'b0);
      run_and_halt(3);

      // T6 oversized count is clamped; start pulses during load are ignored
      load_test(2047, 0, 0, 1'b1);
      run_and_halt(2);

      // Random counts and gaps
      for (int k = 0; k < 4; k++) begin
         load_test($urandom_range(0, 12), $urandom_range(0, 12), 2, 1'b0);
         run_and_halt($urandom_range(1, 10));
      end

      repeat (2) @(negedge clk);
      check("all_writes_seen", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
